// File: rtl/fb_write_arbiter.sv
// ---------------------------------------------------------------------------
// fb_write_arbiter
//
// Purpose:
//   Shares the single framebuffer (index RAM) write port between two
//   requesters, for example a host loader and a fill/blit engine. The port
//   is granted in bursts with round-robin arbitration. The write strobe,
//   address and data are registered. Beats whose address lies outside the
//   visible 800x600 frame are discarded and counted.
//
// Build option:
//   FB_VBLANK_GATE_EN - when defined, beats are only accepted while vblank
//                       is high. When undefined, the vblank input is ignored.
//
// Parameters:
//   ADDR_W    - write address width (19)
//   DATA_W    - colour-index width (8)
//   FB_WORDS  - number of valid words; any address >= FB_WORDS is dropped
//   MAX_BURST - maximum beats per grant before a forced release (>= 1)
//
// Ports:
//   sys_clk      in   sole clock, all logic on the rising edge
//   reset_n      in   asynchronous active-low reset
//   req0_valid   in   requester 0 beat valid
//   req0_addr    in   requester 0 beat address
//   req0_data    in   requester 0 beat data
//   req0_last    in   requester 0 final beat of burst
//   req0_ready   out  requester 0 beat accepted when high with valid
//   req1_*            same set for requester 1
//   vblank       in   vertical-blank flag, already synchronous to sys_clk
//   wr_en        out  registered framebuffer write strobe
//   wr_addr      out  registered framebuffer write address
//   wr_data      out  registered framebuffer write data
//   busy         out  high while a requester owns the port
//   drop_count   out  saturating count of discarded out-of-range beats
// ---------------------------------------------------------------------------
module fb_write_arbiter #(
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 8,
  parameter int FB_WORDS  = 480000,
  parameter int MAX_BURST = 16
) (
  input  logic              sys_clk,
  input  logic              reset_n,

  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_last,
  output logic              req0_ready,

  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              req1_ready,

  input  logic              vblank,

  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic [15:0]       drop_count
);

  // Arbiter states. OWN0/OWN1 mean that requester currently holds the port.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  // The beat counter only has to reach MAX_BURST-1: the MAX_BURST-th beat
  // ends the burst and clears it instead of incrementing.
  localparam int              CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  // The range limit is compared one bit wider than the address so that a
  // frame size equal to 2**ADDR_W would still be representable.
  localparam int               LIMIT_W    = ADDR_W + 1;
  localparam logic [LIMIT_W-1:0] ADDR_LIMIT = LIMIT_W'(FB_WORDS);

  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  logic [1:0]        state_q, state_d;
  logic              last_owner_q, last_owner_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [15:0]       drop_q, drop_d;

  logic              gate_open;
  logic              owning;
  logic              owner_id;
  logic              own_valid;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_data;
  logic              own_last;
  logic              other_valid;
  logic              accept;
  logic              burst_end;
  logic              in_range;

  // Acceptance gate. With the vblank option the current owner keeps the
  // port outside vblank but cannot move beats, so a burst that straddles the
  // end of vblank simply stalls and resumes at the next vblank.
`ifdef FB_VBLANK_GATE_EN
  assign gate_open = vblank;
`else
  logic vblank_unused;
  assign vblank_unused = vblank;
  assign gate_open     = 1'b1;
`endif

  // Ready depends only on ownership and the gate, never on valid, so a
  // requester may raise valid in response to ready without a loop.
  assign req0_ready = (state_q == ST_OWN0) && gate_open;
  assign req1_ready = (state_q == ST_OWN1) && gate_open;

  assign owning = (state_q == ST_OWN0) || (state_q == ST_OWN1);
  assign busy   = (state_q != ST_IDLE);

  // Route the owning requester's beat onto a common set of signals, and
  // pick out the other requester's valid for the handover decision.
  always_comb begin
    owner_id    = 1'b0;
    own_valid   = 1'b0;
    own_addr    = '0;
    own_data    = '0;
    own_last    = 1'b0;
    other_valid = 1'b0;
    case (state_q)
      ST_OWN0: begin
        owner_id    = 1'b0;
        own_valid   = req0_valid;
        own_addr    = req0_addr;
        own_data    = req0_data;
        own_last    = req0_last;
        other_valid = req1_valid;
      end
      ST_OWN1: begin
        owner_id    = 1'b1;
        own_valid   = req1_valid;
        own_addr    = req1_addr;
        own_data    = req1_data;
        own_last    = req1_last;
        other_valid = req0_valid;
      end
      default: begin
        owner_id    = 1'b0;
      end
    endcase
  end

  // A beat moves when the owner is valid and the gate is open. The burst
  // ends on its last beat or on the MAX_BURST-th beat; dropped beats count
  // towards both just like written ones.
  assign accept    = owning && own_valid && gate_open;
  assign burst_end = accept && (own_last || (beat_cnt_q == CNT_LAST));
  assign in_range  = ({1'b0, own_addr} < ADDR_LIMIT);

  // Arbitration and burst tracking. In IDLE a lone request is granted
  // directly; a tie goes to whoever did not own the port last. At the end
  // of a burst a waiting peer takes over on the very next cycle, otherwise
  // the arbiter falls back to IDLE. A requester that lowers valid mid-burst
  // keeps the port indefinitely.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req0_valid && (!req1_valid || last_owner_q)) begin
          state_d = ST_OWN0;
        end else if (req1_valid) begin
          state_d = ST_OWN1;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (burst_end) begin
          last_owner_d = owner_id;
          beat_cnt_d   = '0;
          if (other_valid) begin
            state_d = (state_q == ST_OWN0) ? ST_OWN1 : ST_OWN0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (accept) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        beat_cnt_d = '0;
      end
    endcase
  end

  // Write port and drop counter. Only in-range beats produce a one-cycle
  // write strobe; the address/data registers hold their last written value
  // otherwise. Out-of-range beats bump the counter, which sticks at all-ones.
  always_comb begin
    wr_en_d   = accept && in_range;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    drop_d    = drop_q;
    if (accept && in_range) begin
      wr_addr_d = own_addr;
      wr_data_d = own_data;
    end
    if (accept && !in_range && (drop_q != DROP_MAX)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  // All state returns to reset values immediately on reset_n low, so a beat
  // accepted in the same cycle never reaches the framebuffer. last_owner
  // resets to requester 1 so that requester 0 wins the first tie.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
      beat_cnt_q   <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      drop_q       <= drop_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fb_write_arbiter
//
// Drives both requesters from per-requester beat queues, predicts ready,
// busy, writes and drops with a burst-level model of the arbitration rules,
// and checks the registered write port from a separate monitor process.
// Honours FB_VBLANK_GATE_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_fb_write_arbiter;

  localparam int ADDR_W    = 19;
  localparam int DATA_W    = 8;
  localparam int FB_WORDS  = 480000;
  localparam int MAX_BURST = 16;

`ifdef FB_VBLANK_GATE_EN
  localparam bit GATED = 1'b1;
`else
  localparam bit GATED = 1'b0;
`endif

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  logic              sys_clk = 1'b0;
  logic              reset_n;
  logic              req0_valid, req0_last, req0_ready;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req1_valid, req1_last, req1_ready;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              vblank;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic [15:0]       drop_count;

  int assertCount = 0;
  int failCount   = 0;
  int writeCount  = 0;

  // Pending beats per requester, and writes expected on the port.
  beat_t q0[$];
  beat_t q1[$];
  beat_t expQ[$];

  // Reference model: current owner (-1 = nobody), beats in this grant,
  // last granted requester, expected drop count.
  int mOwner  = -1;
  int mBeats  = 0;
  int mLast   = 1;
  int expDrop = 0;

  bit   gaps     = 1'b0;
  bit   vbRandom = 1'b0;
  logic vbLevel  = 1'b1;

  fb_write_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_WORDS(FB_WORDS), .MAX_BURST(MAX_BURST)
  ) dut (
    .sys_clk(sys_clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req1_last(req1_last), .req1_ready(req1_ready),
    .vblank(vblank),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .drop_count(drop_count)
  );

  // 100 MHz system clock.
  always #5 sys_clk = ~sys_clk;

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Queue a run of consecutive beats on one requester.
  task automatic pushBeats(input int who, input int startAddr, input int count,
                           input int startData, input bit lastAtEnd);
    beat_t b;
    for (int i = 0; i < count; i++) begin
      b.addr = ADDR_W'(startAddr + i);
      b.data = DATA_W'(startData + i);
      b.last = lastAtEnd && (i == count - 1);
      if (who == 0) q0.push_back(b);
      else          q1.push_back(b);
    end
  endtask

  // Queue one random burst (1..20 beats, last on its final beat) mixing
  // in-range, near-boundary and out-of-range addresses.
  task automatic pushRandomBurst(input int who);
    beat_t b;
    int len;
    int sel;
    len = $urandom_range(1, 20);
    for (int i = 0; i < len; i++) begin
      sel = $urandom_range(0, 7);
      if (sel == 0)      b.addr = ADDR_W'($urandom_range(FB_WORDS, (1 << ADDR_W) - 1));
      else if (sel == 1) b.addr = ADDR_W'($urandom_range(FB_WORDS - 4, FB_WORDS + 3));
      else               b.addr = ADDR_W'($urandom_range(0, FB_WORDS - 1));
      b.data = DATA_W'($urandom);
      b.last = (i == len - 1);
      if (who == 0) q0.push_back(b);
      else          q1.push_back(b);
    end
  endtask

  // What an accepted beat should do to the write port or drop counter.
  task automatic recordBeat(input beat_t b);
    if (int'(b.addr) < FB_WORDS) expQ.push_back(b);
    else if (expDrop < 65535)    expDrop++;
  endtask

  // Drive one cycle: present the head beat of each queue, check ready and
  // busy against the model, then advance the model through the next edge.
  task automatic applyStimulus();
    bit    v0, v1, gate, acc0, acc1, endBurst;
    beat_t b0, b1;
    b0 = '{addr: '0, data: '0, last: 1'b0};
    b1 = '{addr: '0, data: '0, last: 1'b0};
    @(negedge sys_clk);
    v0 = (q0.size() > 0) && (!gaps || ($urandom_range(0, 3) != 0));
    v1 = (q1.size() > 0) && (!gaps || ($urandom_range(0, 3) != 0));
    if (q0.size() > 0) b0 = q0[0];
    if (q1.size() > 0) b1 = q1[0];
    req0_valid = v0; req0_addr = b0.addr; req0_data = b0.data; req0_last = b0.last;
    req1_valid = v1; req1_addr = b1.addr; req1_data = b1.data; req1_last = b1.last;
    vblank = vbRandom ? 1'($urandom_range(0, 1)) : vbLevel;
    #1;
    gate = GATED ? vblank : 1'b1;
    checkOutput("req0_ready", 32'(req0_ready), 32'((mOwner == 0) && gate));
    checkOutput("req1_ready", 32'(req1_ready), 32'((mOwner == 1) && gate));
    checkOutput("busy", 32'(busy), 32'(mOwner != -1));
    acc0 = (mOwner == 0) && v0 && gate;
    acc1 = (mOwner == 1) && v1 && gate;
    if (acc0) begin
      void'(q0.pop_front());
      recordBeat(b0);
    end
    if (acc1) begin
      void'(q1.pop_front());
      recordBeat(b1);
    end
    if (mOwner == -1) begin
      if (v0 && v1)  mOwner = 1 - mLast;
      else if (v0)   mOwner = 0;
      else if (v1)   mOwner = 1;
    end else if (acc0 || acc1) begin
      mBeats++;
      endBurst = (acc0 ? b0.last : b1.last) || (mBeats == MAX_BURST);
      if (endBurst) begin
        mLast  = mOwner;
        mBeats = 0;
        if ((mOwner == 0) ? v1 : v0) mOwner = 1 - mOwner;
        else                         mOwner = -1;
      end
    end
  endtask

  // Run cycles until both queues are empty or the budget runs out, then
  // idle two cycles so the last write leaves the port.
  task automatic runUntilDrained(input string name, input int budget);
    int n;
    n = 0;
    while (((q0.size() > 0) || (q1.size() > 0)) && (n < budget)) begin
      applyStimulus();
      n++;
    end
    checkOutput({name, "_drained"}, 32'(q0.size() + q1.size()), 32'd0);
    applyStimulus();
    applyStimulus();
  endtask

  // Write-port monitor: one cycle after each edge the port must show exactly
  // the write the model expects (or none), and the drop counter must agree.
  initial begin : monitor
    beat_t e;
    forever begin
      @(posedge sys_clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("wr_en", 32'(wr_en), 32'd1);
        checkOutput("wr_addr", 32'(wr_addr), 32'(e.addr));
        checkOutput("wr_data", 32'(wr_data), 32'(e.data));
      end else begin
        checkOutput("wr_en_idle", 32'(wr_en), 32'd0);
      end
      if (wr_en) writeCount++;
      checkOutput("drop_count", 32'(drop_count), 32'(expDrop));
    end
  end

  // Main sequence: directed cases first, then random traffic, reset in the
  // middle of a burst, and finally drop-counter saturation.
  initial begin : stimulus
    int w;
    reset_n = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0; req0_last = 1'b0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0; req1_last = 1'b0;
    vblank = 1'b1;
    repeat (2) @(negedge sys_clk);
    #1;
    checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
    checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("rst_wr_data", 32'(wr_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_drop", 32'(drop_count), 32'd0);
    checkOutput("rst_ready0", 32'(req0_ready), 32'd0);
    checkOutput("rst_ready1", 32'(req1_ready), 32'd0);
    @(negedge sys_clk);
    reset_n = 1'b1;

    $display("[TB] single 4-beat burst from req0");
    w = writeCount;
    pushBeats(0, 0, 4, 'h10, 1'b1);
    runUntilDrained("burst4", 50);
    checkOutput("burst4_writes", 32'(writeCount - w), 32'd4);
    checkOutput("burst4_busy", 32'(busy), 32'd0);

    $display("[TB] tie, handover, second tie");
    pushBeats(0, 100, 3, 'h20, 1'b1);
    pushBeats(1, 200, 2, 'h30, 1'b1);
    runUntilDrained("tie1", 50);
    pushBeats(0, 300, 2, 'h34, 1'b1);
    pushBeats(1, 400, 2, 'h38, 1'b1);
    runUntilDrained("tie2", 50);

    $display("[TB] forced release after MAX_BURST beats");
    pushBeats(1, 1000, 20, 'h40, 1'b1);
    applyStimulus();
    applyStimulus();
    pushBeats(0, 2000, 3, 'h80, 1'b1);
    runUntilDrained("forced", 100);

    $display("[TB] range boundary");
    w = writeCount;
    pushBeats(0, FB_WORDS - 1, 2, 'hAA, 1'b1);
    runUntilDrained("boundary", 50);
    checkOutput("boundary_writes", 32'(writeCount - w), 32'd1);
    checkOutput("boundary_drop", 32'(drop_count), 32'd1);

    $display("[TB] vblank gating and stall");
    vbLevel = 1'b0;
    pushBeats(0, 3000, 6, 'h50, 1'b1);
    repeat (4) applyStimulus();
    vbLevel = 1'b1;
    repeat (3) applyStimulus();
    vbLevel = 1'b0;
    repeat (3) applyStimulus();
    vbLevel = 1'b1;
    runUntilDrained("vblank", 50);

    $display("[TB] random traffic");
    gaps = 1'b1;
    vbRandom = 1'b1;
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 2) != 0) pushRandomBurst(0);
      if ($urandom_range(0, 2) != 0) pushRandomBurst(1);
      repeat ($urandom_range(5, 30)) applyStimulus();
    end
    runUntilDrained("random", 4000);
    gaps = 1'b0;
    vbRandom = 1'b0;
    vbLevel = 1'b1;

    $display("[TB] reset in the middle of a req0 burst");
    pushBeats(0, 5000, 8, 'h60, 1'b1);
    repeat (3) applyStimulus();
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_wr_en", 32'(wr_en), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_drop", 32'(drop_count), 32'd0);
    checkOutput("midrst_ready0", 32'(req0_ready), 32'd0);
    q0.delete();
    q1.delete();
    expQ.delete();
    mOwner = -1; mBeats = 0; mLast = 1; expDrop = 0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(negedge sys_clk);
    reset_n = 1'b1;
    pushBeats(1, 6000, 3, 'h70, 1'b1);
    runUntilDrained("after_reset", 50);

    $display("[TB] drop counter saturation");
    for (int i = 0; i < 2050 * MAX_BURST; i++) begin
      beat_t b;
      b.addr = ADDR_W'(FB_WORDS + (i % 40000));
      b.data = DATA_W'(i);
      b.last = 1'b0;
      q0.push_back(b);
      q1.push_back(b);
    end
    runUntilDrained("saturate", 70000);
    checkOutput("saturate_drop", 32'(drop_count), 32'h0000FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
